// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data RAM between the CPU
// load/store path and the UART upload writer, one access per cycle.
module dmem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upg_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              upg_req,
  input  logic              upg_we,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [DATA_W-1:0] upg_wdata,
  output logic              upg_gnt,
  output logic              upg_rvalid,
  output logic [DATA_W-1:0] upg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       busy_cnt
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_CPU,
    SEL_UPG
  } sel_e;

  acc_t cpu_acc;
  acc_t upg_acc;
  acc_t win_acc;
  sel_e sel;

  logic cpu_elig;
  logic upg_elig;
  logic last;
  logic last_nxt;

  logic              cpu_gnt_q;
  logic              upg_gnt_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  logic              tag_vld;
  logic              tag_upg;
  logic              cpu_rvalid_q;
  logic              upg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] upg_rdata_q;
  logic [15:0]       busy_cnt_q;

  assign cpu_acc = {cpu_we, cpu_addr, cpu_wdata};
  assign upg_acc = {upg_we, upg_addr, upg_wdata};

  // A requester in its grant cycle still holds req; masking it
  // here is what forces the one-cycle gap and prevents re-issue.
  assign cpu_elig = cpu_req & ~cpu_gnt_q & ~upg_mode;
  assign upg_elig = upg_req & ~upg_gnt_q;

  always_comb begin
    sel      = SEL_NONE;
    last_nxt = last;
    unique case (1'b1)
      cpu_elig & upg_elig: begin
        sel      = last ? SEL_CPU : SEL_UPG;
        last_nxt = ~last;
      end
      cpu_elig & ~upg_elig: sel = SEL_CPU;
      ~cpu_elig & upg_elig: sel = SEL_UPG;
      default: ;
    endcase
  end

  assign win_acc = (sel == SEL_UPG) ? upg_acc : cpu_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      last        <= 1'b1;
      cpu_gnt_q   <= 1'b0;
      upg_gnt_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      last      <= last_nxt;
      cpu_gnt_q <= (sel == SEL_CPU);
      upg_gnt_q <= (sel == SEL_UPG);
      ram_en_q  <= (sel != SEL_NONE);
      ram_we_q  <= (sel != SEL_NONE) & win_acc.we;
      if (sel != SEL_NONE) begin
        ram_addr_q  <= win_acc.addr;
        ram_wdata_q <= win_acc.wdata;
      end
    end
  end

  // Read owner rides one stage behind the RAM access so the
  // strobe lines up with the synchronous RAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld      <= 1'b0;
      tag_upg      <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      upg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      upg_rdata_q  <= '0;
    end else begin
      tag_vld      <= (sel != SEL_NONE) & ~win_acc.we;
      tag_upg      <= (sel == SEL_UPG);
      cpu_rvalid_q <= tag_vld & ~tag_upg;
      upg_rvalid_q <= tag_vld & tag_upg;
      if (cpu_rvalid_q) begin
        cpu_rdata_q <= ram_rdata;
      end
      if (upg_rvalid_q) begin
        upg_rdata_q <= ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= '0;
    end else if (ram_en_q && busy_cnt_q != 16'hFFFF) begin
      busy_cnt_q <= busy_cnt_q + 16'd1;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign upg_gnt    = upg_gnt_q;
  assign cpu_stall  = cpu_req & ~cpu_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign upg_rvalid = upg_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? ram_rdata : cpu_rdata_q;
  assign upg_rdata  = upg_rvalid_q ? ram_rdata : upg_rdata_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: random and directed traffic on both requesters,
// per-cycle expectations from a reference model, checked by a monitor.
module tb_dmem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          upg_mode;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          upg_req;
  logic          upg_we;
  logic [AW-1:0] upg_addr;
  logic [DW-1:0] upg_wdata;
  logic          upg_gnt;
  logic          upg_rvalid;
  logic [DW-1:0] upg_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [15:0]   busy_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .upg_mode(upg_mode),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .upg_req(upg_req), .upg_we(upg_we),
    .upg_addr(upg_addr), .upg_wdata(upg_wdata),
    .upg_gnt(upg_gnt), .upg_rvalid(upg_rvalid),
    .upg_rdata(upg_rdata),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy_cnt(busy_cnt)
  );

  function automatic logic [DW-1:0] init_word(int a);
    if (a == 16) return 32'hDEADBEEF;
    return DW'(a) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  // Environment RAM: synchronous read, write-through nothing
  logic [DW-1:0] ram_mem [MW];
  logic          ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < MW; i++) ram_mem[i] <= init_word(i);
      ram_loaded <= 1'b1;
      ram_rdata  <= '0;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: expected outputs for the next cycle
  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          cg;
    logic          ug;
    logic          cv;
    logic          uv;
    logic [DW-1:0] crd;
    logic [DW-1:0] urd;
    logic [15:0]   cnt;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur = '{default: '0};
  logic [DW-1:0] ref_mem [MW];
  logic          ref_loaded = 1'b0;
  logic          cpu_pref = 1'b1;

  always @(posedge clk) begin
    exp_t          n;
    logic          ce;
    logic          ue;
    logic [DW-1:0] rd;
    int            win;
    if (!ref_loaded) begin
      for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1'b1;
    end
    rd = '0;
    // the RAM performs this cycle's access even across a reset edge
    if (cur.en) begin
      if (cur.we) ref_mem[cur.addr] = cur.wdata;
      else        rd = ref_mem[cur.addr];
    end
    n = cur;
    if (rst) begin
      n = '{default: '0};
      cpu_pref = 1'b1;
    end else begin
      n.cv = cur.en && !cur.we && cur.cg;
      n.uv = cur.en && !cur.we && cur.ug;
      if (n.cv) n.crd = rd;
      if (n.uv) n.urd = rd;
      if (cur.en && cur.cnt != 16'hFFFF) n.cnt = cur.cnt + 16'd1;
      ce  = cpu_req && !cur.cg && !upg_mode;
      ue  = upg_req && !cur.ug;
      win = 0;
      if (ce && ue) begin
        win      = cpu_pref ? 1 : 2;
        cpu_pref = (win == 2);
      end else if (ce) begin
        win = 1;
      end else if (ue) begin
        win = 2;
      end
      n.en = (win != 0);
      n.cg = (win == 1);
      n.ug = (win == 2);
      if (win == 1) begin
        n.we = cpu_we; n.addr = cpu_addr; n.wdata = cpu_wdata;
      end else if (win == 2) begin
        n.we = upg_we; n.addr = upg_addr; n.wdata = upg_wdata;
      end
    end
    cur = n;
    exp_q.push_back(n);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ram_en", 32'(ram_en), 32'(e.en));
      chk("cpu_gnt", 32'(cpu_gnt), 32'(e.cg));
      chk("upg_gnt", 32'(upg_gnt), 32'(e.ug));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.cv));
      chk("upg_rvalid", 32'(upg_rvalid), 32'(e.uv));
      chk("cpu_rdata", cpu_rdata, e.crd);
      chk("upg_rdata", upg_rdata, e.urd);
      chk("busy_cnt", 32'(busy_cnt), 32'(e.cnt));
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e.cg));
      if (e.en) begin
        chk("ram_we", 32'(ram_we), 32'(e.we));
        chk("ram_addr", 32'(ram_addr), 32'(e.addr));
        chk("ram_wdata", ram_wdata, e.wdata);
      end
    end
  end

  // Stimulus
  logic cpu_done = 1'b0;
  logic upg_done = 1'b0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic new_cpu();
    cpu_req   = 1'b1;
    cpu_we    = 1'($urandom_range(1));
    cpu_addr  = AW'($urandom_range(63));
    cpu_wdata = $urandom;
  endtask

  task automatic new_upg();
    upg_req   = 1'b1;
    upg_we    = 1'($urandom_range(1));
    upg_addr  = AW'($urandom_range(63));
    upg_wdata = $urandom;
  endtask

  task automatic idle_all();
    cpu_req  = 1'b0;
    upg_req  = 1'b0;
    cpu_done = 1'b0;
    upg_done = 1'b0;
  endtask

  task automatic tick(int cpu_pct, int upg_pct);
    step();
    if (cpu_done) begin cpu_done = 1'b0; cpu_req = 1'b0; end
    if (!cpu_req && int'($urandom_range(99)) < cpu_pct) new_cpu();
    else if (cpu_req && !cpu_gnt && $urandom_range(99) < 2) cpu_req = 1'b0;
    if (cpu_req && cpu_gnt) cpu_done = 1'b1;
    if (upg_done) begin upg_done = 1'b0; upg_req = 1'b0; end
    if (!upg_req && int'($urandom_range(99)) < upg_pct) new_upg();
    else if (upg_req && !upg_gnt && $urandom_range(99) < 2) upg_req = 1'b0;
    if (upg_req && upg_gnt) upg_done = 1'b1;
  endtask

  task automatic cpu_single(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    bit seen = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (cpu_gnt) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL cpu_single_timeout addr=%h got=no_gnt want=gnt", a);
    end
    step();
    cpu_req = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; upg_mode = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    upg_req = 1'b0; upg_we = 1'b0; upg_addr = '0; upg_wdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    cpu_single(1'b0, AW'(16), '0);
    cpu_single(1'b1, AW'(4), 32'h12345678);
    cpu_single(1'b0, AW'(4), '0);

    rst = 1'b1; step(); rst = 1'b0;
    repeat (10) tick(100, 100);
    idle_all(); repeat (3) step();

    upg_mode = 1'b1;
    repeat (10) tick(100, 100);
    upg_mode = 1'b0;
    repeat (6) tick(100, 100);
    idle_all(); repeat (3) step();

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(99) < 3) upg_mode = ~upg_mode;
      tick(int'($urandom_range(100)), int'($urandom_range(100)));
    end
    upg_mode = 1'b0;
    idle_all(); repeat (3) step();

    cpu_single(1'b1, AW'(20), 32'hCAFEF00D);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(20);
    for (int i = 0; i < 10 && !cpu_gnt; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_all();
    repeat (6) tick(100, 100);
    idle_all(); repeat (3) step();

    repeat (65600) tick(100, 100);
    idle_all(); repeat (4) step();
    chk("busy_cnt_saturated", 32'(busy_cnt), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
